// File: rtl/dbg_uart_bridge.sv
// UART-to-debug bridge: gathers a 9-byte host frame (cmd, addr, data; LSB first),
// issues it to the core, then returns a 4-byte response or 0xDEADBEEF on timeout.
module dbg_uart_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   resp_q, resp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_q, timeout_d;
    logic          rx_fire, tx_fire;

    assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign tx_valid_o = (state_q == S_RESP);
    assign busy_o     = (state_q != S_IDLE);
    assign timeout_o  = timeout_q;
    assign dbg_cmd_o  = (state_q == S_EXEC) ? cmd_q : '0;
    assign dbg_addr_o = addr_q;
    assign dbg_data_o = data_q;
    assign tx_data_o  = resp_q[{cnt_q, 3'b000} +: 8];

    assign rx_fire = rx_valid_i && rx_ready_o;
    assign tx_fire = tx_valid_o && tx_ready_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_fire && (rx_data_i != 8'h00)) begin
                    cmd_d   = rx_data_i;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    data_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_EXEC;
                        tmo_d   = '0;
                    end
                end
            end
            S_EXEC: begin
                // A completion on the final allowed cycle beats the timeout.
                if (dbg_ready_i) begin
                    resp_d  = dbg_data_i;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    resp_d    = 32'hDEAD_BEEF;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Randomized scoreboard bench for dbg_uart_bridge: host driver, behavioural core
// model and an independent monitor comparing DUT outputs against queued expectations.
module tb_dbg_uart_bridge;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    logic        busy_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    dbg_uart_bridge #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .dbg_cmd_o  (dbg_cmd_o),
        .dbg_addr_o (dbg_addr_o),
        .dbg_data_o (dbg_data_o),
        .dbg_data_i (dbg_data_i),
        .dbg_ready_i(dbg_ready_i),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } frame_t;

    frame_t      exp_frame_q[$];
    logic [7:0]  exp_tx_q[$];
    bit          exp_to_q[$];
    int          delay_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit core_en  = 1'b0;
    bit tx_rand  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    endtask

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        finish_sim();
    end

    // Transmitter: mostly ready, occasional single stalls and 5-cycle stalls.
    initial begin
        int stall = 0;
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!tx_rand) tx_ready_i = 1'b1;
            else if (stall > 0) begin
                tx_ready_i = 1'b0;
                stall--;
            end else if ($urandom_range(0, 15) == 0) begin
                tx_ready_i = 1'b0;
                stall = 4;
            end else tx_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Core model: a completion arriving within TMO exec cycles returns its data,
    // otherwise the bridge answers 0xDEADBEEF and flags a timeout.
    initial begin
        bit          prev_nz = 1'b0;
        int          cd = 0;
        int          d;
        logic [31:0] rdata = '0;
        logic [31:0] resp;
        dbg_ready_i = 1'b0;
        dbg_data_i  = '0;
        forever begin
            @(negedge clk);
            dbg_ready_i = 1'b0;
            dbg_data_i  = $urandom;
            if (!mon_en) begin
                prev_nz = 1'b0;
            end else if ((dbg_cmd_o != 8'h00) && !prev_nz) begin
                d = (delay_q.size() > 0) ? delay_q.pop_front() : -1;
                if (d < 0) begin
                    case ($urandom_range(0, 4))
                        0, 1:    d = $urandom_range(0, 5);
                        2:       d = TMO - 1;
                        3:       d = TMO;
                        default: d = TMO + $urandom_range(1, 3);
                    endcase
                end
                if (core_en) begin
                    rdata = $urandom;
                    resp  = (d <= TMO - 1) ? rdata : 32'hDEADBEEF;
                    for (int k = 0; k < 4; k++) exp_tx_q.push_back(8'((resp >> (8 * k)) & 32'hFF));
                    exp_to_q.push_back(d > TMO - 1);
                    if (d == 0) begin
                        dbg_ready_i = 1'b1;
                        dbg_data_i  = rdata;
                    end else cd = d;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dbg_ready_i = 1'b1;
                    dbg_data_i  = rdata;
                end
            end else if (!busy_o && $urandom_range(0, 7) == 0) begin
                dbg_ready_i = 1'b1;
            end
            prev_nz = mon_en && (dbg_cmd_o != 8'h00);
        end
    end

    // Monitor.
    initial begin
        bit          prev_nz = 1'b0;
        bit          prev_txv = 1'b0;
        bit          prev_stall = 1'b0;
        logic [7:0]  prev_data = '0;
        logic [7:0]  cur_cmd = '0;
        logic [31:0] cur_addr = '0;
        frame_t      f;
        forever begin
            @(negedge clk);
            if (mon_en && !rst_i) begin
                if ((dbg_cmd_o != 8'h00) && !prev_nz) begin
                    if (exp_frame_q.size() == 0) chk("unexpected_exec", 32'(dbg_cmd_o), 32'h0);
                    else begin
                        f = exp_frame_q.pop_front();
                        cur_cmd  = f.cmd;
                        cur_addr = f.addr;
                        chk("dbg_addr", dbg_addr_o, f.addr);
                        chk("dbg_data", dbg_data_o, f.data);
                    end
                end
                if (dbg_cmd_o != 8'h00) begin
                    chk("dbg_cmd_exec", 32'(dbg_cmd_o), 32'(cur_cmd));
                    chk("exec_busy_rxr_txv", {busy_o, rx_ready_o, tx_valid_o}, 3'b100);
                end
                if (tx_valid_o && !prev_txv) begin
                    chk("cmd_clear_in_resp", 32'(dbg_cmd_o), 32'h0);
                    if (exp_to_q.size() == 0) chk("unexpected_resp", 32'(tx_valid_o), 32'h0);
                    else chk("timeout_pulse", 32'(timeout_o), 32'(exp_to_q.pop_front()));
                end else chk("timeout_spurious", 32'(timeout_o), 32'h0);
                if (prev_stall) chk("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, prev_data});
                if (tx_valid_o && tx_ready_i) begin
                    chk("addr_hold", dbg_addr_o, cur_addr);
                    if (exp_tx_q.size() == 0) chk("unexpected_tx", 32'(tx_data_o), 32'h0);
                    else chk("tx_byte", 32'(tx_data_o), 32'(exp_tx_q.pop_front()));
                end
                prev_nz    = (dbg_cmd_o != 8'h00);
                prev_txv   = tx_valid_o;
                prev_stall = tx_valid_o && !tx_ready_i;
                prev_data  = tx_data_o;
            end else begin
                prev_nz    = 1'b0;
                prev_txv   = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        int w  = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!ok) begin
            @(negedge clk);
            ok = rx_ready_o;
            @(posedge clk);
            #1;
            w++;
            if (!ok && w > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_accept: rx_ready_o low for %0d cycles, expected accept", w);
                finish_sim();
            end
        end
        rx_valid_i = 1'b0;
        rx_data_i  = $urandom;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input int d);
        frame_t f;
        f.cmd  = cmd;
        f.addr = addr;
        f.data = data;
        exp_frame_q.push_back(f);
        delay_q.push_back(d);
        send_byte(cmd);
        for (int k = 0; k < 4; k++) send_byte(8'((addr >> (8 * k)) & 32'hFF));
        for (int k = 0; k < 4; k++) send_byte(8'((data >> (8 * k)) & 32'hFF));
    endtask

    task automatic wait_idle();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((busy_o || exp_tx_q.size() != 0) && w < 500);
        chk("drain_idle", 32'(busy_o), 32'h0);
    endtask

    initial begin
        int w;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready_o), 32'h1);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
        chk("rst_tx_data", 32'(tx_data_o), 32'h0);
        chk("rst_cmd", 32'(dbg_cmd_o), 32'h0);
        chk("rst_addr", dbg_addr_o, 32'h0);
        chk("rst_data", dbg_data_o, 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Abort a frame mid-EXEC with reset; the core stays silent for this one.
        core_en = 1'b0;
        send_frame(8'h5A, 32'h1234_5678, 32'h9ABC_DEF0, TMO + 3);
        w = 0;
        while (dbg_cmd_o == 8'h00 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("exec_reached", 32'(dbg_cmd_o), 32'h5A);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("abort_cmd", 32'(dbg_cmd_o), 32'h0);
        chk("abort_busy", 32'(busy_o), 32'h0);
        chk("abort_tx_valid", 32'(tx_valid_o), 32'h0);
        chk("abort_rx_ready", 32'(rx_ready_o), 32'h1);
        chk("abort_addr", dbg_addr_o, 32'h0);
        @(posedge clk);
        #1;
        core_en = 1'b1;
        tx_rand = 1'b1;

        send_frame(8'h01, 32'h8000_0010, 32'hDEAD_BEEF, 3);
        send_byte(8'h00);
        send_frame(8'($urandom_range(1, 255)), $urandom, $urandom, TMO - 1);
        send_frame(8'($urandom_range(1, 255)), $urandom, $urandom, TMO + 1);
        send_frame(8'($urandom_range(1, 255)), $urandom, $urandom, TMO);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'h00);
            send_frame(8'($urandom_range(1, 255)), $urandom, $urandom, -1);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("frames_left", 32'(exp_frame_q.size()), 32'h0);
        chk("tx_left", 32'(exp_tx_q.size()), 32'h0);
        chk("timeouts_left", 32'(exp_to_q.size()), 32'h0);
        finish_sim();
    end

endmodule

// File: doc/dbg_uart_bridge.md
DBG_UART_BRIDGE -- requirements
Module: dbg_uart_bridge

Interface
REQ-001: Parameter TIMEOUT, default 1024, SHALL set the maximum EXEC cycles spent waiting for dbg_ready_i (minimum 2).
REQ-002: clk  input  1  sole clock; all logic SHALL be on the rising edge.
REQ-003: rst_i  input  1  reset; synchronous and active-high.
REQ-004: rx_data_i  input  8  host byte from UART receiver.
REQ-005: rx_valid_i  input  1  rx_data_i valid.
REQ-006: rx_ready_o  output  1  bridge accepts a byte this cycle.
REQ-007: tx_data_o  output  8  response byte to UART transmitter.
REQ-008: tx_valid_o  output  1  tx_data_o valid.
REQ-009: tx_ready_i  input  1  transmitter accepts tx_data_o.
REQ-010: dbg_cmd_o  output  8  debug command to core; 0x00 = no command.
REQ-011: dbg_addr_o  output  32  debug address.
REQ-012: dbg_data_o  output  32  debug write data.
REQ-013: dbg_data_i  input  32  debug read data from core.
REQ-014: dbg_ready_i  input  1  core completion strobe.
REQ-015: busy_o  output  1  high in every state except IDLE.
REQ-016: timeout_o  output  1  one-cycle pulse on transaction timeout.

Function
REQ-017: Host frame SHALL be 9 bytes: cmd, addr[7:0..31:24], data[7:0..31:24] (LSB first).
REQ-018: FSM SHALL have states IDLE, ADDR, DATA, EXEC, RESP; 2-bit byte counter indexes ADDR/DATA/RESP bytes.
REQ-019: A byte SHALL be consumed only when rx_valid_i && rx_ready_o; rx_ready_o SHALL be 1 in IDLE/ADDR/DATA, 0 in EXEC/RESP.
REQ-020: IDLE: consumed byte 0x00 SHALL be discarded (stay IDLE); nonzero byte SHALL be latched as cmd, go ADDR, counter=0.
REQ-021: ADDR/DATA: byte k SHALL be written to bits [8k+7:8k] of dbg_addr_o/dbg_data_o; after k=3 go DATA/EXEC respectively.
REQ-022: dbg_cmd_o SHALL equal latched cmd in the cycle after the last data byte is consumed and for every EXEC cycle; 0x00 otherwise.
REQ-023: EXEC: timeout counter SHALL start at 0 on entry and increment each cycle dbg_ready_i is low.
REQ-024: EXEC with dbg_ready_i=1: capture dbg_data_i into response register, go RESP; dbg_cmd_o SHALL be 0x00 the next cycle.
REQ-025: EXEC with counter==TIMEOUT-1 and dbg_ready_i=0: response register=0xDEADBEEF, timeout_o=1 for one cycle, go RESP.
REQ-026: dbg_ready_i and timeout in same cycle: ready SHALL win, no timeout_o.
REQ-027: dbg_ready_i outside EXEC SHALL be ignored.
REQ-028: RESP: tx_valid_o=1, tx_data_o=response byte[counter] (LSB first); advance on tx_valid_o && tx_ready_i; after byte 3 go IDLE.
REQ-029: tx_data_o SHALL be stable while tx_valid_o && !tx_ready_i.
REQ-030: dbg_addr_o/dbg_data_o SHALL hold last values outside ADDR/DATA loading.
REQ-031: Latency: last rx byte to dbg_cmd_o valid = 1 cycle; dbg_ready_i to tx_valid_o = 1 cycle.

Reset
REQ-032: On rst_i=1 at clk edge: state IDLE, counters 0, dbg_cmd_o=0x00, dbg_addr_o=0, dbg_data_o=0, response=0, tx_valid_o=0, tx_data_o=0, busy_o=0, timeout_o=0, rx_ready_o=1 after reset deasserts.
REQ-033: Reset in any state (incl. mid-EXEC) SHALL abort the frame; dbg_cmd_o SHALL be 0x00 from the next cycle.

Verification
REQ-034: Frame 01,10,00,00,80,EF,BE,AD,DE; dbg_ready_i high 3 cycles after cmd -> dbg_addr_o=0x80000010, dbg_data_o=0xDEADBEEF, dbg_cmd_o=0x01 until ready, tx bytes = dbg_data_i LSB first.
REQ-035: TIMEOUT=8, dbg_ready_i held 0 -> timeout_o pulses once after 8 EXEC cycles, tx bytes EF,BE,AD,DE, then IDLE.
REQ-036: Byte 0x00 then full frame -> 0x00 discarded, frame executes normally.
REQ-037: tx_ready_i low 5 cycles during RESP byte 1 -> tx_data_o stable, no byte lost or duplicated.
REQ-038: rst_i asserted in EXEC -> next cycle dbg_cmd_o=0x00, busy_o=0, tx_valid_o=0; subsequent frame completes.
REQ-039: dbg_ready_i pulsed in IDLE and on the TIMEOUT-1 cycle -> first ignored, second captured, timeout_o stays 0.
